// File: rtl/crc_seq_ctrl.sv
// Sequential CRC long-division controller: one GF(2) division step per clock,
// with valid/ready handshakes on the job input and the remainder output.
module crc_seq_ctrl #(
    parameter int unsigned MSG_W  = 9,
    parameter int unsigned POLY_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MSG_W-1:0]  msg_in,
    input  logic [POLY_W-1:0] poly_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [POLY_W-2:0] crc_out,
    output logic              crc_zero,
    output logic              poly_err,
    output logic              busy
);
    localparam int unsigned STEPS = MSG_W - POLY_W + 1;
    localparam int unsigned SHW   = MSG_W - POLY_W;
    localparam int unsigned REM_W = POLY_W - 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q;
    logic [POLY_W-1:0] work_q;
    logic [REM_W-1:0]  poly_q;
    logic [SHW-1:0]    msg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [REM_W-1:0]  crc_q;
    logic              crc_zero_q;
    logic              poly_err_q;
    logic [REM_W-1:0]  rem_c;

    // Polynomial MSB is known to be 1 once accepted, so only the low bits are stored.
    always_comb begin
        rem_c = work_q[REM_W-1:0] ^ (work_q[POLY_W-1] ? poly_q : REM_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            poly_q      <= '0;
            msg_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            crc_q       <= '0;
            crc_zero_q  <= 1'b0;
            poly_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (!poly_in[POLY_W-1]) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            crc_q       <= '0;
                            crc_zero_q  <= 1'b0;
                            poly_err_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            poly_q  <= poly_in[REM_W-1:0];
                            work_q  <= msg_in[MSG_W-1 -: POLY_W];
                            msg_q   <= msg_in[SHW-1:0];
                            cnt_q   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        crc_q       <= rem_c;
                        crc_zero_q  <= (rem_c == REM_W'(0));
                        poly_err_q  <= 1'b0;
                    end else begin
                        // Shadow register shifts left so its MSB is always the next message bit.
                        work_q <= {rem_c, msg_q[SHW-1]};
                        msg_q  <= msg_q << 1;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign crc_out   = crc_q;
    assign crc_zero  = crc_zero_q;
    assign poly_err  = poly_err_q;

endmodule
